// File: rtl/iic_rx.sv
// I2C target write receiver: oversamples SCL/SDA, tracks START/STOP, ACKs its own
// write address plus register/data bytes, and emits one register-write strobe per data byte.
module iic_rx #(
  parameter int                         DEVICE_ADDR_LEN = 7,
  parameter logic [DEVICE_ADDR_LEN-1:0] DEVICE_ADDR     = 7'h3C,
  parameter int                         REG_ADDR_LEN    = 8,
  parameter int                         DATA_LEN        = 8,
  parameter int                         SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    scl,
  inout  wire                     sda,
  output logic                    wr_valid,
  output logic [REG_ADDR_LEN-1:0] wr_reg_addr,
  output logic [DATA_LEN-1:0]     wr_data,
  output logic                    busy
);

  localparam int ADDR_FIELD = DEVICE_ADDR_LEN + 1;
  localparam int MAX_AR     = (ADDR_FIELD > REG_ADDR_LEN) ? ADDR_FIELD : REG_ADDR_LEN;
  localparam int MAX_LEN    = (MAX_AR > DATA_LEN) ? MAX_AR : DATA_LEN;
  localparam int CNT_W      = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    DATA,
    DATA_ACK
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  scl_sync;
  logic [SYNC_STAGES-1:0]  sda_sync;
  logic                    scl_d;
  logic                    sda_d;
  logic [MAX_LEN-2:0]      shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    ack_high;
  logic                    sda_oe;
  logic [REG_ADDR_LEN-1:0] reg_ptr;

  logic               scl_s;
  logic               sda_s;
  logic               scl_rise;
  logic               scl_fall;
  logic               start_det;
  logic               stop_det;
  logic [MAX_LEN-1:0] shift_next;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  // SCL must be high on both sides of the SDA edge so a data change near an SCL edge is not misread
  assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
  assign shift_next = {shift_reg, sda_s};

  assign sda  = sda_oe ? 1'b0 : 1'bz;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync    <= '1;
      sda_sync    <= '1;
      scl_d       <= 1'b1;
      sda_d       <= 1'b1;
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      ack_high    <= 1'b0;
      sda_oe      <= 1'b0;
      reg_ptr     <= '0;
      wr_valid    <= 1'b0;
      wr_reg_addr <= '0;
      wr_data     <= '0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      wr_valid <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= DEV_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= CNT_W'(ADDR_FIELD);
      end else begin
        case (state)
          DEV_ADDR, REG_ADDR, DATA: begin
            if (scl_rise && bit_cnt != '0) begin
              shift_reg <= shift_next[MAX_LEN-2:0];
              bit_cnt   <= bit_cnt - 1'b1;
              if (bit_cnt == CNT_W'(1)) begin
                // A mismatch or read request is NACKed simply by never driving SDA
                if (state == DEV_ADDR &&
                    (shift_next[DEVICE_ADDR_LEN:1] != DEVICE_ADDR || shift_next[0])) begin
                  state <= IDLE;
                end else if (state == REG_ADDR) begin
                  reg_ptr <= shift_next[REG_ADDR_LEN-1:0];
                end else if (state == DATA) begin
                  wr_valid    <= 1'b1;
                  wr_reg_addr <= reg_ptr;
                  wr_data     <= shift_next[DATA_LEN-1:0];
                  reg_ptr     <= reg_ptr + 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt == '0) begin
              sda_oe   <= 1'b1;
              ack_high <= 1'b0;
              state    <= (state == DEV_ADDR) ? DEV_ACK :
                          (state == REG_ADDR) ? REG_ACK : DATA_ACK;
            end
          end
          DEV_ACK, REG_ACK, DATA_ACK: begin
            if (scl_rise) begin
              ack_high <= 1'b1;
            end else if (scl_fall && ack_high) begin
              sda_oe <= 1'b0;
              if (state == DEV_ACK) begin
                state   <= REG_ADDR;
                bit_cnt <= CNT_W'(REG_ADDR_LEN);
              end else begin
                state   <= DATA;
                bit_cnt <= CNT_W'(DATA_LEN);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
